// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies stop once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = $clog2(N) + 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         Start,
  input  logic [2:0]   Op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Flush,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] HI,
  output logic [N-1:0] LO
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q, done_q;
  logic [N-1:0]   hi_q, lo_q;
  logic           is_div_q, neg_q, rem_neg_q;
  // Multiply: acc_q = product, x_q = shifted multiplicand, y_q = remaining multiplier.
  // Divide: acc_q[N-1:0] = partial remainder, x_q[N-1:0] = dividend/quotient, y_q = divisor.
  logic [2*N-1:0] acc_q, x_q;
  logic [N-1:0]   y_q;

  logic [2*N-1:0] acc_d, x_d, prod_fix;
  logic [N-1:0]   y_d, quo_fix, rem_fix;
  logic [N:0]     rem_sh, rem_diff;
  logic           last_iter;
  logic           op_signed, sa, sb;
  logic [N-1:0]   abs_a, abs_b;

  always_comb begin
    acc_d    = acc_q;
    x_d      = x_q;
    y_d      = y_q;
    rem_sh   = {acc_q[N-1:0], x_q[N-1]};
    rem_diff = rem_sh - {1'b0, y_q};
    if (is_div_q) begin
      acc_d = {{N{1'b0}}, (rem_diff[N] ? rem_sh[N-1:0] : rem_diff[N-1:0])};
      x_d   = {x_q[2*N-2:0], ~rem_diff[N]};
    end else begin
      acc_d = acc_q + (y_q[0] ? x_q : {(2*N){1'b0}});
      x_d   = x_q << 1;
      y_d   = y_q >> 1;
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign last_iter = (cnt_q == CW'(1)) || (!is_div_q && (y_d == '0));
`else
  assign last_iter = (cnt_q == CW'(1));
`endif

  assign prod_fix = neg_q ? -acc_d : acc_d;
  assign quo_fix  = neg_q ? -x_d[N-1:0] : x_d[N-1:0];
  assign rem_fix  = rem_neg_q ? -acc_d[N-1:0] : acc_d[N-1:0];

  assign op_signed = (Op == 3'd0) || (Op == 3'd2);
  assign sa        = op_signed & A[N-1];
  assign sb        = op_signed & B[N-1];
  assign abs_a     = sa ? -A : A;
  assign abs_b     = sb ? -B : B;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StRun: begin
          if (Flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
            cnt_q <= cnt_q - CW'(1);
            if (last_iter) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= '0;
              if (is_div_q) begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
              end else begin
                hi_q <= prod_fix[2*N-1:N];
                lo_q <= prod_fix[N-1:0];
              end
            end
          end
        end
        default: begin
          state_q <= StIdle;
          if (Start && !Flush) begin
            case (Op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                state_q   <= StRun;
                busy_q    <= 1'b1;
                cnt_q     <= CW'(N);
                acc_q     <= '0;
                x_q       <= {{N{1'b0}}, abs_a};
                y_q       <= abs_b;
                is_div_q  <= Op[1];
                // Divide by zero keeps the all-ones quotient unnegated.
                neg_q     <= (sa ^ sb) & ~(Op[1] & (B == '0));
                rem_neg_q <= sa;
              end
              3'd4:    hi_q <= A;
              3'd5:    lo_q <= A;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle integer multiply/divide unit that owns the architectural HI/LO registers for the core. It is parametrised in operand width N: 32 for MULT/DIV and 64 for MIPS III DMULT/DDIV. The core issues an operation with a one-cycle Start strobe, then stalls while Busy=1. It reads results through HI/LO (MFHI/MFLO) and writes them directly with MTHI/MTLO.

Parameters:
N, 32, operand/result width; legal values 32 or 64.
CW, $clog2(N)+1, iteration counter width (derived; do not override).

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  reset, synchronous, active-high.
Start  input  1  issue strobe; sampled only when Busy=0.
Op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no effect).
A  input  N  rs operand: multiplicand / dividend / MTHI-MTLO data.
B  input  N  rt operand: multiplier / divisor.
Flush  input  1  abort the in-flight operation (exception/branch squash).
Busy  output  1  high while an operation iterates; core stalls MFHI/MFLO/new issue.
Done  output  1  one-cycle pulse when HI/LO hold a new mul/div result.
HI  output  N  HI register (high product / remainder).
LO  output  N  LO register (low product / quotient).

Behaviour:
- Reset: state IDLE; Busy=0, Done=0, HI=0, LO=0, counter=0. RST overrides Start and Flush in the same cycle. RST during RUN discards the operation.
- States are IDLE, RUN and DONE. Busy=1 only in RUN. Done=1 only in DONE.
- Accept: on an edge with Busy=0 and Start=1 (in IDLE or DONE):
  - Op 0-3: latch |A| and |B| (sign-magnitude for signed ops, raw for unsigned), latch result-sign flags, load counter=N, go to RUN.
  - Op 4: HI<=A. Op 5: LO<=A. Both stay in IDLE with no Done pulse.
  - Op 6-7: ignored.
- Start while Busy=1 is ignored. The operands are not re-sampled.
- RUN, multiply: radix-2 shift-add, one multiplier bit per cycle, 2N-bit accumulator.
- RUN, divide: restoring division, one quotient bit per cycle, N-bit partial remainder.
- The counter decrements each RUN cycle. On the edge where it reaches 0, the unit applies sign correction and writes HI/LO, then goes to DONE.
- Sign rules, signed ops:
  - Product is negated if sign(A)^sign(B).
  - Quotient is negated if sign(A)^sign(B).
  - Remainder takes the sign of A.
- Latency: Start accepted at end of cycle 0 gives Busy=1 in cycles 1..N, and Done=1 with new HI/LO in cycle N+1 (cycle 33 for N=32).
- DONE lasts exactly one cycle, then returns to IDLE unless a new Start is accepted in DONE, which allows back-to-back issue.
- Divide by zero (B=0, DIV or DIVU): full latency, LO=all ones, HI=A (unmodified dividend).
- Signed overflow (A=most-negative, B=-1): LO=most-negative, HI=0; this falls out of the magnitude datapath and needs no special case.
- Flush=1 in RUN: go to IDLE on that edge; HI/LO unchanged; no Done.
- Flush=1 in IDLE or DONE: no effect on state, but it blocks a simultaneous Start, so nothing is accepted.
- HI/LO outputs are register values with no bypass: they are updated only by DONE entry, MTHI/MTLO, or reset.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: multiply (Op 0/1) runs max(1, index of highest set bit of |B| + 1) iterations, i.e. it stops once the remaining multiplier bits are zero. Done follows the last iteration by one cycle; results are identical.
- Not defined: all multiplies take exactly N iterations.
- Divide latency is always N, in both builds.

Test Plan:
1. N=32, MULT A=0xFFFFFFFD (-3), B=7 -> Busy cycles 1..32, Done cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
2. MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIVU A=0x12345678, B=0 -> Done cycle 33, LO=0xFFFFFFFF, HI=0x12345678. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. MTHI A=0xA5A5A5A5, then MULT 2*3 with Flush in cycle 10 -> Busy falls cycle 11, no Done, HI=0xA5A5A5A5 retained. RST in cycle 5 of a DIV -> Busy=0, HI=LO=0 next cycle.
5. Start in the DONE cycle of a MULTU 4*5 (LO=20) with DIVU 100/7 -> accepted, LO=14, HI=2 after a further 33 cycles. A Start asserted while Busy=1 has no effect.
6. MULDIV_EARLY_OUT_EN defined, MULTU A=5, B=3 -> Done cycle 3, LO=15, HI=0. B=0 -> Done cycle 2, HI=LO=0. N=64 DMULTU 2^32 * 2^32 -> HI=1, LO=0, Done cycle 34 (33 iterations) with the macro, cycle 65 without.
